fft_result_collector: RTL and testbench

Receiving end of the FFT output stream. Captures the 2N-word burst the FFT core emits while `finish` is high: N real words, then N imaginary words. It then re-presents the results as complex bins (real and imaginary together) over a valid/ready handshake. An optional bit-reversal on the read index restores natural order when the core emits in bit-reversed order. It sits between the FFT core output (`finish`/`answer`) and downstream consumers such as a magnitude unit or host readout.

---
 rtl/fft_result_collector.sv | 138 +++++++++++++
 tb/tb_fft_result_collector.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_collector.sv
// fft_result_collector
// Captures the 2N-word FFT output burst (N real words, then N imaginary
// words) and replays it as complex bins over a valid/ready handshake.
// An optional bit-reversal on the read index restores natural bin order.
module fft_result_collector #(
  parameter int N      = 32,
  parameter int LOGN   = 5,
  parameter int W      = 17,
  parameter int BITREV = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            finish_i,
  input  logic [W-1:0]    answer_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [W-1:0]    out_re_o,
  output logic [W-1:0]    out_im_o,
  output logic [LOGN-1:0] out_idx_o,
  output logic            frame_done_o,
  output logic            ovf_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [LOGN:0]   LAST_WORD = (LOGN+1)'(2*N-1);
  localparam logic [LOGN-1:0] LAST_BIN  = LOGN'(N-1);

  state_t          r_state;
  logic [LOGN:0]   r_wr_cnt;   // word number within the burst, 0..2N-1
  logic [LOGN-1:0] r_rd_cnt;   // bin number being presented, 0..N-1
  logic            r_valid;
  logic            r_done;
  logic            r_ovf;

  logic [W-1:0]    r_re_buf [N];
  logic [W-1:0]    r_im_buf [N];

  logic            w_wr_en;
  logic            w_wr_im;
  logic [LOGN-1:0] w_wr_addr;
  logic [LOGN-1:0] w_rd_slot;

  // Words are accepted in IDLE (as word 0, wr_cnt is 0 there) and COLLECT;
  // anything arriving while draining is dropped and flagged instead.
  assign w_wr_en   = rst_n && finish_i && (r_state != DRAIN);
  assign w_wr_im   = r_wr_cnt[LOGN];
  assign w_wr_addr = r_wr_cnt[LOGN-1:0];

  // Read slot: natural index, or its LOGN-bit reversal when the core emits
  // in bit-reversed order.
  always_comb begin
    w_rd_slot = r_rd_cnt;
    if (BITREV != 0) begin
      for (int i = 0; i < LOGN; i++) begin
        w_rd_slot[i] = r_rd_cnt[LOGN-1-i];
      end
    end
  end

  // Result storage: upper half of the burst goes to the imaginary buffer.
  // NOTE: the buffers carry no reset; every slot is rewritten by a complete
  // frame before it is ever read, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (w_wr_im) begin
        r_im_buf[w_wr_addr] <= answer_i;
      end else begin
        r_re_buf[w_wr_addr] <= answer_i;
      end
    end
  end

  // Frame control: collect 2N words, then drain N bins, then pulse done.
  // NOTE: all state here uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (finish_i) begin
            r_wr_cnt <= (LOGN+1)'(1);
            r_state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (finish_i) begin
            if (r_wr_cnt == LAST_WORD) begin
              r_wr_cnt <= '0;
              r_rd_cnt <= '0;
              r_valid  <= 1'b1;
              r_state  <= DRAIN;
            end else begin
              r_wr_cnt <= r_wr_cnt + (LOGN+1)'(1);
            end
          end
        end
        DRAIN: begin
          if (finish_i) begin
            r_ovf <= 1'b1;
          end
          if (out_ready_i) begin
            if (r_rd_cnt == LAST_BIN) begin
              r_rd_cnt <= '0;
              r_valid  <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= IDLE;
            end else begin
              r_rd_cnt <= r_rd_cnt + LOGN'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Data outputs read as zero whenever no bin is being offered.
  assign out_valid_o  = r_valid;
  assign out_idx_o    = r_valid ? r_rd_cnt : '0;
  assign out_re_o     = r_valid ? r_re_buf[w_rd_slot] : '0;
  assign out_im_o     = r_valid ? r_im_buf[w_rd_slot] : '0;
  assign frame_done_o = r_done;
  assign ovf_o        = r_ovf;

endmodule

// File: tb/tb_fft_result_collector.sv
// Testbench for fft_result_collector: two instances (natural and bit-reversed
// read order) share one stimulus and are compared every cycle against a
// frame-level reference model, plus directed checks of the notable cases.
module tb_fft_result_collector;

  localparam int N    = 32;
  localparam int LOGN = 5;
  localparam int W    = 17;

  typedef logic [W-1:0] frame_t [2*N];

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            finish_i = 1'b0;
  logic [W-1:0]    answer_i = '0;
  logic            out_ready_i = 1'b0;

  logic            v0, v1, d0, d1, f0, f1;
  logic [W-1:0]    re0, im0, re1, im1;
  logic [LOGN-1:0] x0, x1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fft_result_collector #(.N(N), .LOGN(LOGN), .W(W), .BITREV(0)) dut_nat (
    .clk(clk), .rst_n(rst_n), .finish_i(finish_i), .answer_i(answer_i),
    .out_valid_o(v0), .out_ready_i(out_ready_i), .out_re_o(re0), .out_im_o(im0),
    .out_idx_o(x0), .frame_done_o(d0), .ovf_o(f0)
  );

  fft_result_collector #(.N(N), .LOGN(LOGN), .W(W), .BITREV(1)) dut_rev (
    .clk(clk), .rst_n(rst_n), .finish_i(finish_i), .answer_i(answer_i),
    .out_valid_o(v1), .out_ready_i(out_ready_i), .out_re_o(re1), .out_im_o(im1),
    .out_idx_o(x1), .frame_done_o(d1), .ovf_o(f1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int rev(input int x);
    int r = 0;
    for (int i = 0; i < LOGN; i++) r = r * 2 + ((x >> i) & 1);
    return r;
  endfunction

  // ---------------- reference model (frame level) ----------------
  logic [W-1:0] m_frame [2*N];
  int  m_cnt   = 0;
  bit  m_drain = 0;
  int  m_k     = 0;
  bit  m_ovf   = 0;
  bit  m_done  = 0;
  bit  m_en    = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_drain = 0; m_k = 0; m_ovf = 0; m_done = 0; m_en = 1;
    end else begin
      m_done = 0;
      if (m_drain) begin
        if (finish_i) m_ovf = 1;
        if (out_ready_i) begin
          if (m_k == N - 1) begin m_drain = 0; m_done = 1; end
          else m_k++;
        end
      end else if (finish_i) begin
        m_frame[m_cnt] = answer_i;
        m_cnt++;
        if (m_cnt == 2 * N) begin m_drain = 1; m_k = 0; m_cnt = 0; end
      end
    end
  end

  task automatic cmp(input string n, input bit br, input logic v, input logic [LOGN-1:0] x,
                     input logic [W-1:0] re, input logic [W-1:0] im, input logic d, input logic f);
    int s;
    s = br ? rev(m_k) : m_k;
    check({n, "_valid"}, v, m_drain);
    check({n, "_idx"}, x, m_drain ? m_k : 0);
    check({n, "_re"}, re, m_drain ? m_frame[s] : '0);
    check({n, "_im"}, im, m_drain ? m_frame[N + s] : '0);
    check({n, "_done"}, d, m_done);
    check({n, "_ovf"}, f, m_ovf);
  endtask

  always @(negedge clk) begin
    if (m_en) begin
      cmp("nat", 1'b0, v0, x0, re0, im0, d0, f0);
      cmp("rev", 1'b1, v1, x1, re1, im1, d1, f1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input frame_t w, input int gap_at, input int gap_pct, input bit chk_done);
    for (int j = 0; j < 2 * N; j++) begin
      finish_i = 1'b1;
      answer_i = w[j];
      if (j == 0 && chk_done) begin
        @(negedge clk);
        check("b2b_done_cycle", d0, 1);
      end
      tick();
      finish_i = 1'b0;
      answer_i = W'($urandom);
      if (j == gap_at) repeat (3) tick();
      else if (j != 2 * N - 1 && $urandom_range(0, 99) < gap_pct) repeat ($urandom_range(1, 2)) tick();
    end
  endtask

  task automatic drain_frame(input bit rnd);
    int  cyc  = 0;
    bit  seen = 0;
    while (!seen && cyc < 1000) begin
      @(negedge clk);
      if (d0) seen = 1;
      out_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      cyc++;
    end
    check("drain_completes", seen, 1);
    out_ready_i = 1'b1;
  endtask

  task automatic wait_bin(input int k);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(v0 && x0 == LOGN'(k)) && c < 300);
    check("reach_bin", (v0 && x0 == LOGN'(k)), 1);
  endtask

  frame_t ident, w;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit any_done;
    for (int j = 0; j < 2 * N; j++) ident[j] = W'(j);

    // Reset
    tick(); tick();
    @(negedge clk);
    check("rst_valid", v0, 0);
    check("rst_re", re0, 0);
    check("rst_ovf", f0, 0);
    rst_n = 1'b1;
    tick();

    // Identity frame, ready tied high
    out_ready_i = 1'b1;
    send_frame(ident, -1, 0, 1'b0);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check("id_valid", v0, 1);
      check("id_idx", x0, k);
      check("id_re", re0, k);
      check("id_im", im0, N + k);
      if (k == 1)  begin check("br1_re", re1, 16); check("br1_im", im1, 48); end
      if (k == 3)  begin check("br3_re", re1, 24); check("br3_im", im1, 56); end
      if (k == 31) begin check("br31_re", re1, 31); check("br31_im", im1, 63); end
    end
    @(negedge clk);
    check("id_done", d0, 1);
    check("id_valid_after", v0, 0);
    @(negedge clk);
    check("id_done_once", d0, 0);

    // Gaps after word 10, backpressure at bin 7
    send_frame(ident, 10, 0, 1'b0);
    wait_bin(7);
    out_ready_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_idx", x0, 7);
      check("stall_re", re0, 7);
      check("stall_im", im0, 39);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    check("after_stall_idx", x0, 8);
    drain_frame(1'b0);

    // Negative values, random gaps and ready
    for (int j = 0; j < 2 * N; j++) w[j] = W'($urandom);
    w[0] = 17'h1FFFF;
    w[N] = 17'h10000;
    send_frame(w, -1, 20, 1'b0);
    @(negedge clk);
    check("neg_re", re0, 17'h1FFFF);
    check("neg_im", im0, 17'h10000);
    drain_frame(1'b1);

    // Overflow: word arrives during drain
    send_frame(ident, -1, 0, 1'b0);
    wait_bin(5);
    finish_i = 1'b1;
    answer_i = W'($urandom);
    tick();
    finish_i = 1'b0;
    @(negedge clk);
    check("ovf_set", f0, 1);
    drain_frame(1'b0);
    check("ovf_sticky", f0, 1);

    // Back-to-back: next frame starts in the frame_done cycle
    for (int j = 0; j < 2 * N; j++) w[j] = W'($urandom);
    send_frame(w, -1, 0, 1'b0);
    wait_bin(N - 1);
    tick();
    for (int j = 0; j < 2 * N; j++) w[j] = W'($urandom);
    send_frame(w, -1, 10, 1'b1);
    drain_frame(1'b1);

    // Reset at wr_cnt=40
    for (int j = 0; j < 40; j++) begin
      finish_i = 1'b1; answer_i = W'(j); tick();
    end
    finish_i = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", v0, 0);
    check("midrst_ovf", f0, 0);
    send_frame(ident, -1, 0, 1'b0);
    @(negedge clk);
    check("postrst_re0", re0, 0);
    check("postrst_im0", im0, N);
    drain_frame(1'b1);

    // Reset during drain
    send_frame(ident, -1, 0, 1'b0);
    wait_bin(10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("drainrst_valid", v0, 0);
    any_done = 0;
    repeat (40) begin
      @(negedge clk);
      any_done |= d0;
    end
    check("drainrst_no_done", any_done, 0);

    // Random frames
    repeat (3) begin
      for (int j = 0; j < 2 * N; j++) w[j] = W'($urandom);
      send_frame(w, -1, 25, 1'b0);
      drain_frame(1'b1);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
